// File: rtl/synth_bus_pkg.sv
// Shared parameter-bus and SysEx definitions for the synth engine.
// Bank enumeration, bank tags, message bytes and bank sizing.
package synth_bus_pkg;

  typedef enum logic [1:0] {
    BK_OSC,
    BK_COM,
    BK_M1,
    BK_M2
  } bank_e;

  localparam logic [7:0] TAG_OSC  = 8'h10;
  localparam logic [7:0] TAG_COM  = 8'h11;
  localparam logic [7:0] TAG_M1   = 8'h12;
  localparam logic [7:0] TAG_M2   = 8'h13;

  localparam logic [7:0] SYX_F0   = 8'hF0;
  localparam logic [7:0] SYX_F7   = 8'hF7;
  localparam logic [7:0] SYX_MFR  = 8'h7D;
  localparam logic [7:0] CMD_DUMP = 8'h01;

  function automatic logic [7:0] bank_size(
    input bank_e b,
    input int    v_osc
  );
    if (b == BK_COM) return 8'd16;
    return 8'(v_osc * 16);
  endfunction

  function automatic logic [7:0] bank_tag(
    input bank_e b
  );
    logic [7:0] t;
    unique case (b)
      BK_OSC:  t = TAG_OSC;
      BK_COM:  t = TAG_COM;
      BK_M1:   t = TAG_M1;
      default: t = TAG_M2;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/param_bus_reader.sv
// Single parameter read: SETUP, RDH, RDL, CAP.
// Address/bank are held from SETUP until the next start.
module param_bus_reader (
  input  logic       sCLK_XVXENVS,
  input  logic       iRST,
  input  logic       start,
  input  logic [6:0] adr_in,
  input  logic [1:0] bank_in,
  input  logic [7:0] bus_data_in,
  output logic [6:0] adr,
  output logic [1:0] bank,
  output logic       read,
  output logic [7:0] data,
  output logic       done
);

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_SETUP,
    RD_RDH,
    RD_RDL,
    RD_CAP
  } rd_e;

  rd_e state, state_n;

  always_ff @(posedge sCLK_XVXENVS) begin
    if (iRST) state <= RD_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      RD_IDLE:  if (start) state_n = RD_SETUP;
      RD_SETUP: state_n = RD_RDH;
      RD_RDH:   state_n = RD_RDL;
      RD_RDL:   state_n = RD_CAP;
      RD_CAP:   state_n = RD_IDLE;
      default:  state_n = RD_IDLE;
    endcase
  end

  always_comb begin
    read = (state == RD_RDH);
    done = (state == RD_CAP);
  end

  always_ff @(posedge sCLK_XVXENVS) begin
    if (iRST) begin
      adr  <= '0;
      bank <= '0;
      data <= '0;
    end else begin
      if (start && state == RD_IDLE) begin
        adr  <= adr_in;
        bank <= bank_in;
      end
      if (state == RD_CAP) data <= bus_data_in;
    end
  end

endmodule

// File: rtl/patch_dump_sysex_tx.sv
// Patch dump: reads every bank over the parameter bus and
// streams a nibblized, checksummed SysEx message to the UART.
module patch_dump_sysex_tx
  import synth_bus_pkg::*;
#(
  parameter int         V_OSC  = 4,
  parameter logic [6:0] DEV_ID = 7'h00
) (
  input  logic       sCLK_XVXENVS,
  input  logic       iRST,
  input  logic       dump_req,
  input  logic [7:0] bus_data_in,
  output logic [6:0] adr,
  output logic       read,
  output logic       osc_sel,
  output logic       com_sel,
  output logic       m1_sel,
  output logic       m2_sel,
  output logic       sysex_data_patch_send,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR,
    ST_TAG,
    ST_RD,
    ST_NIBH,
    ST_NIBL,
    ST_CKSUM,
    ST_EOX,
    ST_DONE
  } st_e;

  st_e        state, state_n;
  logic [1:0] hdr_idx;
  logic [1:0] bank_cnt;
  logic [1:0] rd_bank;
  logic [6:0] adr_cnt;
  logic [6:0] start_adr;
  logic [6:0] sum;
  logic [6:0] ck;
  logic [7:0] rd_data;
  logic       start;
  logic       rd_done;
  logic       adr_last;
  logic       last_bank;
  logic       nib_st;

  assign adr_last  = ({1'b0, adr_cnt} ==
                      bank_size(bank_e'(bank_cnt), V_OSC) - 8'd1);
  assign last_bank = (bank_cnt == 2'd3);
  assign ck        = 7'd0 - sum;
  assign nib_st    = (state == ST_TAG) || (state == ST_NIBH) ||
                     (state == ST_NIBL);
  assign start_adr = (state == ST_NIBL) ? adr_cnt + 7'd1 : adr_cnt;
  assign start     = tx_ready && ((state == ST_TAG) ||
                     (state == ST_NIBL && !adr_last));

  param_bus_reader u_rd (
    .sCLK_XVXENVS (sCLK_XVXENVS),
    .iRST         (iRST),
    .start        (start),
    .adr_in       (start_adr),
    .bank_in      (bank_cnt),
    .bus_data_in  (bus_data_in),
    .adr          (adr),
    .bank         (rd_bank),
    .read         (read),
    .data         (rd_data),
    .done         (rd_done)
  );

  always_ff @(posedge sCLK_XVXENVS) begin
    if (iRST) state <= ST_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:  if (dump_req) state_n = ST_HDR;
      ST_HDR:   if (tx_ready && hdr_idx == 2'd3) state_n = ST_TAG;
      ST_TAG:   if (tx_ready) state_n = ST_RD;
      ST_RD:    if (rd_done) state_n = ST_NIBH;
      ST_NIBH:  if (tx_ready) state_n = ST_NIBL;
      ST_NIBL:
        if (tx_ready) begin
          if (!adr_last)      state_n = ST_RD;
          else if (last_bank) state_n = ST_CKSUM;
          else                state_n = ST_TAG;
        end
      ST_CKSUM: if (tx_ready) state_n = ST_EOX;
      ST_EOX:   if (tx_ready) state_n = ST_DONE;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state)
      ST_IDLE: busy = 1'b0;
      ST_HDR: begin
        tx_valid = 1'b1;
        unique case (hdr_idx)
          2'd0:    tx_data = SYX_F0;
          2'd1:    tx_data = SYX_MFR;
          2'd2:    tx_data = {1'b0, DEV_ID};
          default: tx_data = CMD_DUMP;
        endcase
      end
      ST_TAG: begin
        tx_valid = 1'b1;
        tx_data  = bank_tag(bank_e'(bank_cnt));
      end
      ST_NIBH: begin
        tx_valid = 1'b1;
        tx_data  = {4'h0, rd_data[7:4]};
      end
      ST_NIBL: begin
        tx_valid = 1'b1;
        tx_data  = {4'h0, rd_data[3:0]};
      end
      ST_CKSUM: begin
        tx_valid = 1'b1;
        tx_data  = {1'b0, ck};
      end
      ST_EOX: begin
        tx_valid = 1'b1;
        tx_data  = SYX_F7;
      end
      ST_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Bank selects follow the bank latched by the reader.
  assign osc_sel = busy && (bank_e'(rd_bank) == BK_OSC);
  assign com_sel = busy && (bank_e'(rd_bank) == BK_COM);
  assign m1_sel  = busy && (bank_e'(rd_bank) == BK_M1);
  assign m2_sel  = busy && (bank_e'(rd_bank) == BK_M2);
  assign sysex_data_patch_send = busy;

  always_ff @(posedge sCLK_XVXENVS) begin
    if (iRST || state == ST_IDLE) begin
      hdr_idx  <= '0;
      adr_cnt  <= '0;
      bank_cnt <= '0;
      sum      <= '0;
    end else begin
      if (state == ST_HDR && tx_ready) hdr_idx <= hdr_idx + 2'd1;
      if (nib_st && tx_ready) sum <= sum + tx_data[6:0];
      if (state == ST_NIBL && tx_ready) begin
        if (adr_last) begin
          adr_cnt  <= '0;
          bank_cnt <= bank_cnt + 2'd1;
        end else begin
          adr_cnt  <= adr_cnt + 7'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_patch_dump_sysex_tx.sv
// Directed bench for patch_dump_sysex_tx with a memory responder
// and a byte-capturing UART sink.
module tb_patch_dump_sysex_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dump_req = 1'b0;
  logic       tx_ready = 1'b0;
  logic [7:0] bus_data_in;
  logic [6:0] adr;
  logic       read;
  logic       osc_sel, com_sel, m1_sel, m2_sel;
  logic       sps;
  logic [7:0] tx_data;
  logic       tx_valid, busy, done;

  int compared = 0;
  int mismatched = 0;
  int nprint = 0;

  logic [7:0] mem [4][128];
  logic [7:0] exp_b [512];
  int         n_exp;
  logic [7:0] exp_ck;
  logic [7:0] got [1024];
  int         n_got, n_done, n_f0, n_cyc;
  logic       first_busy, first_sps;
  logic [7:0] first_tx;
  logic [3:0] sel_at_rst;

  always #5 clk = ~clk;

  patch_dump_sysex_tx #(.V_OSC(4), .DEV_ID(7'h00)) dut (
    .sCLK_XVXENVS          (clk),
    .iRST                  (rst),
    .dump_req              (dump_req),
    .bus_data_in           (bus_data_in),
    .adr                   (adr),
    .read                  (read),
    .osc_sel               (osc_sel),
    .com_sel               (com_sel),
    .m1_sel                (m1_sel),
    .m2_sel                (m2_sel),
    .sysex_data_patch_send (sps),
    .tx_data               (tx_data),
    .tx_valid              (tx_valid),
    .tx_ready              (tx_ready),
    .busy                  (busy),
    .done                  (done)
  );

  always_comb begin
    bus_data_in = 8'h00;
    if (osc_sel)      bus_data_in = mem[0][adr];
    else if (com_sel) bus_data_in = mem[1][adr];
    else if (m1_sel)  bus_data_in = mem[2][adr];
    else if (m2_sel)  bus_data_in = mem[3][adr];
  end

  task automatic clear_mem(input bit pattern);
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 128; a++)
        mem[b][a] = pattern ? 8'(((b << 5) ^ a) & 'h7F) : 8'h00;
  endtask

  task automatic build_exp();
    int sum;
    int sz;
    sum = 0;
    exp_b[0] = 8'hF0;
    exp_b[1] = 8'h7D;
    exp_b[2] = 8'h00;
    exp_b[3] = 8'h01;
    n_exp = 4;
    for (int b = 0; b < 4; b++) begin
      exp_b[n_exp] = 8'(8'h10 + b);
      sum += 'h10 + b;
      n_exp++;
      sz = (b == 1) ? 16 : 64;
      for (int a = 0; a < sz; a++) begin
        exp_b[n_exp]   = {4'h0, mem[b][a][7:4]};
        exp_b[n_exp+1] = {4'h0, mem[b][a][3:0]};
        sum += mem[b][a][7:4] + mem[b][a][3:0];
        n_exp += 2;
      end
    end
    exp_ck = 8'((-sum) & 'h7F);
    exp_b[n_exp]   = exp_ck;
    exp_b[n_exp+1] = 8'hF7;
    n_exp += 2;
  endtask

  task automatic start_dump();
    @(negedge clk);
    rst = 1'b0;
    dump_req = 1'b1;
  endtask

  task automatic collect(input int pct, input int mid_req,
                         input bit req_done, input int rst_at,
                         input int max_cyc);
    logic       pr, pr2, pv, pvr, fin;
    logic [6:0] pa;
    logic [3:0] ps, s;
    logic [7:0] pd;
    pr = 0; pr2 = 0; pv = 0; pvr = 0; fin = 0;
    pa = adr; pd = 8'h00;
    ps = {osc_sel, com_sel, m1_sel, m2_sel};
    n_got = 0; n_done = 0; n_f0 = 0; n_cyc = 0;
    for (int c = 0; c < max_cyc && !fin; c++) begin
      @(negedge clk);
      dump_req = 1'b0;
      rst = 1'b0;
      if (c == mid_req) dump_req = 1'b1;
      tx_ready = ($urandom_range(99) < pct);
      s = {osc_sel, com_sel, m1_sel, m2_sel};
      if (c == 0) begin
        first_busy = busy;
        first_sps = sps;
        first_tx = tx_data;
      end
      if (c == rst_at) begin
        rst = 1'b1;
        sel_at_rst = s;
        fin = 1'b1;
      end
      if (busy || done) n_cyc++;
      if (tx_valid && tx_ready && n_got < 1024) begin
        got[n_got] = tx_data;
        if (tx_data == 8'hF0) n_f0++;
        n_got++;
      end
      if (pv && !pvr) begin
        compared++;
        if (!tx_valid || tx_data !== pd) begin
          mismatched++;
          if (nprint++ < 20)
            $display("FAIL tx_hold c=%0d got %h/%b want %h/1",
                     c, tx_data, tx_valid, pd);
        end
      end
      if (read) begin
        compared++;
        if (pr) begin
          mismatched++;
          if (nprint++ < 20)
            $display("FAIL read_pulse c=%0d got 2 cycles want 1", c);
        end
      end
      if (read || pr || pr2) begin
        compared++;
        if (adr !== pa || s !== ps) begin
          mismatched++;
          if (nprint++ < 20)
            $display("FAIL adr_stable c=%0d got %h/%b want %h/%b",
                     c, adr, s, pa, ps);
        end
      end
      compared++;
      if ($countones(s) > 1 || (read && $countones(s) != 1)) begin
        mismatched++;
        if (nprint++ < 20)
          $display("FAIL sel_onehot c=%0d got %b want one-hot", c, s);
      end
      if (done) begin
        n_done++;
        fin = 1'b1;
        if (req_done) dump_req = 1'b1;
      end
      pr2 = pr; pr = read; pa = adr; ps = s;
      pv = tx_valid; pvr = tx_ready; pd = tx_data;
    end
    if (!fin) begin
      compared++;
      mismatched++;
      $display("FAIL timeout got no done within %0d cycles", max_cyc);
    end
  endtask

  task automatic compare_stream(input string nm);
    int bad;
    bad = 0;
    compared++;
    if (n_got !== n_exp) begin
      mismatched++;
      $display("FAIL %s_len got %0d want %0d", nm, n_got, n_exp);
    end
    for (int i = 0; i < n_exp && i < n_got; i++) begin
      compared++;
      if (got[i] !== exp_b[i]) begin
        mismatched++;
        if (bad++ < 5)
          $display("FAIL %s_byte[%0d] got %h want %h",
                   nm, i, got[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if ({adr, read, osc_sel, com_sel, m1_sel, m2_sel, sps}
        !== 13'h0) begin
      mismatched++;
      $display("FAIL rst_bus got adr=%h rd=%b sel=%b sps=%b want 0",
               adr, read, {osc_sel, com_sel, m1_sel, m2_sel}, sps);
    end
    compared++;
    if (tx_data !== 8'h00 || tx_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_tx got %h/%b want 00/0", tx_data, tx_valid);
    end
    compared++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_busy got %b/%b want 0/0", busy, done);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] want [11];
    clear_mem(1'b0);
    mem[0][2] = 8'h40;
    mem[1][1] = 8'h40;
    build_exp();
    start_dump();
    collect(100, -1, 1'b0, -1, 3000);
    compared++;
    if (first_busy !== 1'b1 || first_sps !== 1'b1 ||
        first_tx !== 8'hF0) begin
      mismatched++;
      $display("FAIL start_lat got busy=%b sps=%b tx=%h want 1 1 F0",
               first_busy, first_sps, first_tx);
    end
    want = '{8'hF0, 8'h7D, 8'h00, 8'h01, 8'h10, 8'h00, 8'h00,
             8'h00, 8'h00, 8'h04, 8'h00};
    for (int i = 0; i < 11; i++) begin
      compared++;
      if (got[i] !== want[i]) begin
        mismatched++;
        $display("FAIL basic_head[%0d] got %h want %h",
                 i, got[i], want[i]);
      end
    end
    compared++;
    if (n_got !== 426 || got[425] !== 8'hF7) begin
      mismatched++;
      $display("FAIL basic_len got %0d last %h want 426 F7",
               n_got, got[425]);
    end
    compared++;
    if (got[424] !== 8'h32) begin
      mismatched++;
      $display("FAIL basic_cksum got %h want 32", got[424]);
    end
    compared++;
    if (n_cyc !== 1259) begin
      mismatched++;
      $display("FAIL basic_cycles got %0d want 1259", n_cyc);
    end
    compare_stream("basic");
    @(negedge clk);
    compared++;
    if (busy !== 1'b0 || sps !== 1'b0) begin
      mismatched++;
      $display("FAIL basic_idle got busy=%b sps=%b want 0 0",
               busy, sps);
    end
  endtask

  task automatic test_pattern();
    clear_mem(1'b1);
    build_exp();
    start_dump();
    collect(100, -1, 1'b0, -1, 3000);
    compare_stream("pattern");
  endtask

  task automatic test_random_ready();
    clear_mem(1'b1);
    build_exp();
    start_dump();
    collect(30, 500, 1'b1, -1, 8000);
    compare_stream("rnd");
    compared++;
    if (n_f0 !== 1 || n_done !== 1) begin
      mismatched++;
      $display("FAIL rnd_restart got f0=%0d done=%0d want 1 1",
               n_f0, n_done);
    end
    @(negedge clk);
    dump_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      compared++;
      if (busy !== 1'b0 || tx_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL req_at_done got busy=%b valid=%b want 0 0",
                 busy, tx_valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_mem(1'b1);
    build_exp();
    start_dump();
    collect(100, -1, 1'b0, 600, 700);
    compared++;
    if (sel_at_rst !== 4'b0010) begin
      mismatched++;
      $display("FAIL mid_bank got sel=%b want 0010", sel_at_rst);
    end
    @(negedge clk);
    compared++;
    if ({adr, read, osc_sel, com_sel, m1_sel, m2_sel, sps, tx_data,
         tx_valid, busy, done} !== 24'h0) begin
      mismatched++;
      $display("FAIL mid_rst got adr=%h rd=%b tx=%h v=%b busy=%b want 0",
               adr, read, tx_data, tx_valid, busy);
    end
    rst = 1'b0;
    start_dump();
    collect(100, -1, 1'b0, -1, 3000);
    compare_stream("after_rst");
  endtask

  task automatic test_last_ff();
    clear_mem(1'b0);
    mem[3][63] = 8'hFF;
    build_exp();
    start_dump();
    collect(100, -1, 1'b0, -1, 3000);
    compared++;
    if (got[422] !== 8'h0F || got[423] !== 8'h0F) begin
      mismatched++;
      $display("FAIL ff_nib got %h %h want 0F 0F", got[422], got[423]);
    end
    compared++;
    if (got[424] !== 8'h1C || got[425] !== 8'hF7) begin
      mismatched++;
      $display("FAIL ff_tail got %h %h want 1C F7", got[424], got[425]);
    end
    compared++;
    if (n_done !== 1 || n_got !== 426) begin
      mismatched++;
      $display("FAIL ff_done got done=%0d n=%0d want 1 426",
               n_done, n_got);
    end
    compare_stream("ff");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pattern();
    test_random_ready();
    test_reset_mid();
    test_last_ff();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
